// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the decode stage.
// Tracks in-flight register writes over DEPTH post-decode stages and derives
// forward selects, stall/flush/bubble controls and saturating event counters.
module hazard_scoreboard #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 1,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FW         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic              dec_use_rs,
  input  logic              dec_use_rt,
  input  logic              dec_reg_write,
  input  logic [REG_AW-1:0] dec_dest,
  input  logic              dec_is_load,
  input  logic              branch_taken,
  input  logic              ext_flush,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Entry 0 = execute ... entry DEPTH-1 = writeback.
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][REG_AW-1:0] dest_q,  dest_d;
  logic [DEPTH-1:0]             load_q,  load_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]             flush_cnt_q, flush_cnt_d;

  logic haz_a, haz_b, stall;

  // Returns {hazard, fwd}: the youngest matching entry decides both, so an
  // unavailable young load blocks forwarding from an older matching entry.
  function automatic logic [FW:0] lookup(
    input logic                         use_s,
    input logic [REG_AW-1:0]            src,
    input logic [DEPTH-1:0]             valid_v,
    input logic [DEPTH-1:0][REG_AW-1:0] dest_v,
    input logic [DEPTH-1:0]             load_v
  );
    logic          found;
    logic          haz;
    logic [FW-1:0] fwd;
    found = 1'b0;
    haz   = 1'b0;
    fwd   = '0;
    if (use_s && (src != '0)) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!found && valid_v[k] && (dest_v[k] == src)) begin
          found = 1'b1;
          if (load_v[k] && (k < LOAD_STAGE)) haz = 1'b1;
          else                               fwd = FW'(k + 1);
        end
      end
    end
    return {haz, fwd};
  endfunction

  // Forward selects and pipeline control from state plus decode fields.
  always_comb begin
    {haz_a, fwd_a} = lookup(dec_use_rs, dec_rs, valid_q, dest_q, load_q);
    {haz_b, fwd_b} = lookup(dec_use_rt, dec_rt, valid_q, dest_q, load_q);
    stall   = dec_valid & (haz_a | haz_b) & ~ext_flush;
    stall_f = stall;
    stall_d = stall;
    flush_e = stall | ext_flush;
    // A stalled branch resolved on stale operands, so it is not honoured.
    flush_d = ext_flush | (branch_taken & dec_valid & ~stall);
  end

  // Next entry contents: shift toward writeback, bubble on flush_e.
  always_comb begin
    valid_d    = '0;
    dest_d     = '0;
    load_d     = '0;
    valid_d[0] = ~flush_e & dec_valid & dec_reg_write & (dec_dest != '0);
    dest_d[0]  = dec_dest;
    load_d[0]  = dec_is_load;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      dest_d[k]  = dest_q[k-1];
      load_d[k]  = load_q[k-1];
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))   stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_d && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      dest_q      <= '0;
      load_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      dest_q      <= dest_d;
      load_q      <= load_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the pipelined datapath. It replaces the fixed five-stage hazard logic.
- Tracks in-flight register writes across a configurable number of post-decode stages. Computes decode-stage forward selects, stall, flush and bubble controls.
- Keeps saturating stall and flush counters for performance analysis.
- Sits beside the decode stage: inputs come from decoded instruction fields and the control unit; outputs drive PC enable, the decode register, the execute register and the decode forward muxes.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, number of tracked stages after decode (entry 0 = execute … entry DEPTH-1 = writeback); minimum 2.
- LOAD_STAGE, 1, first entry index at which load data can be forwarded (1 = memory stage); 0 < LOAD_STAGE < DEPTH.
- CNT_W, 32, performance counter width.
- FW, $clog2(DEPTH+1), forward select width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- dec_valid  in  1  decode register holds a real instruction
- dec_rs, dec_rt  in  REG_AW  source register addresses
- dec_use_rs, dec_use_rt  in  1  instruction reads that source
- dec_reg_write  in  1  instruction writes a register
- dec_dest  in  REG_AW  destination register (already regDst-resolved)
- dec_is_load  in  1  instruction is a load
- branch_taken  in  1  decode-stage branch resolved taken
- ext_flush  in  1  external redirect (exception/restart), kills decode
- stall_f  out  1  hold PC
- stall_d  out  1  hold decode register
- flush_d  out  1  clear decode register at next edge
- flush_e  out  1  insert bubble into execute register at next edge
- fwd_a, fwd_b  out  FW  0 = register file, k+1 = result of tracked entry k
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- State: DEPTH entries {valid, dest, is_load}. All outputs are combinational from state plus decode inputs. State and counters update on posedge clk.
- Reset (async): all entries invalid; counters 0. Hence stall_f = stall_d = flush_d = flush_e = 0 and fwd_a = fwd_b = 0 while rst is high.
- An entry is created only if dec_valid & dec_reg_write & dec_dest != 0. Register 0 is never tracked and never forwarded.
- Match for source s: s is used, s != 0, and the entry is valid with dest == s. The youngest matching entry (lowest index) wins.
- Availability: a non-load entry is available at any index. A load entry is available only at index >= LOAD_STAGE.
- Forward select: fwd = youngest match index + 1 if it is available, else 0.
- Hazard: the youngest match is not available → hazard = 1.
- stall = dec_valid & hazard & ~ext_flush; stall_f = stall_d = stall.
- flush_e = stall | ext_flush, so a bubble enters execute.
- flush_d = ext_flush | (branch_taken & dec_valid & ~stall). branch_taken is ignored while stalled because its operands are stale.
- Shift every edge: entry[k] ← entry[k-1] for k ≥ 1. Entry[0] ← new decode entry unless flush_e, in which case entry[0] becomes invalid. The writeback entry retires.
- Latency:
  - A load-use pair with default parameters stalls exactly LOAD_STAGE cycles.
  - An ALU-to-dependent pair stalls 0 cycles with fwd = 1.
- Counters:
  - stall_cnt +1 on each edge with stall = 1.
  - flush_cnt +1 on each edge with flush_d = 1.
  - Both hold at 2^CNT_W − 1 (no wrap).
- Simultaneous events:
  - ext_flush overrides stall and branch.
  - rs and rt are evaluated independently; a hazard on either stalls.
  - A mid-operation reset clears all state immediately.

Test Plan:
- ALU hazard: add r3 in execute, decode reads r3 on rs → fwd_a = 1, stall = 0. Next cycle r3 in memory → fwd_a = 2. Then writeback → fwd_a = 3. Then fwd_a = 0.
- Load-use: load r5, then a dependent instruction on rt → stall_f = stall_d = flush_e = 1 for 1 cycle, then fwd_b = 2, stall_cnt = 1.
- Register zero and priority: older write to r0, decode reads r0 → fwd = 0, no stall. Two in-flight writes to r7 → youngest selected (fwd = 1, not 2).
- Branch: branch_taken with no hazard → flush_d = 1, flush_cnt + 1. branch_taken during a load-use stall → flush_d = 0. ext_flush during a stall → stall = 0, flush_d = flush_e = 1.
- Parameter sweep DEPTH = 4, LOAD_STAGE = 2: load then dependent → 2 stall cycles then fwd = 3. Force CNT_W = 4 with 20 stalls → stall_cnt = 15.
- Async reset mid-stall: rst pulse between edges → all outputs 0 immediately; no stale forwarding after release.
